// File: rtl/pipe_test_sequencer.sv
// On-chip stimulus sequencer and checker for the two-stage registered gate datapath.
// Drives counter/LFSR vectors on a_out and compares dut_b against a cycle-accurate model.
module pipe_test_sequencer #(
  parameter int CNT_W   = 8,
  parameter bit SAT_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             mode,
  input  logic [6:0]       seed,
  output logic [6:0]       a_out,
  input  logic             dut_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] num_reg;
  logic [CNT_W-1:0] idx_reg;
  logic [CNT_W-1:0] cmp_idx_reg;
  logic             mode_reg;
  logic [6:0]       a_prev_reg;
  logic             vld0_reg;
  logic             vld1_reg;
  logic             exp_reg;
  logic             exp_vld_reg;
  logic             err_seen_reg;

  logic [6:0]       a_next;
  logic [6:0]       seed_eff;
  logic             mismatch;
  logic             err_full;

  function automatic logic f4(input logic [6:0] v);
    return ~(v[0] & v[1]) & ~v[2];
  endfunction

  function automatic logic f5(input logic [6:0] v);
    return v[3] | v[4] | (v[5] & v[6]);
  endfunction

  always_comb begin
    a_next   = mode_reg ? {a_out[5:0], a_out[6] ^ a_out[5]} : a_out + 7'd1;
    // An all-zero LFSR state would lock up, so a zero seed starts at 1.
    seed_eff = (mode && (seed == 7'd0)) ? 7'h01 : seed;
    mismatch = exp_vld_reg && (dut_b != exp_reg);
    err_full = &err_count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      num_reg       <= '0;
      idx_reg       <= '0;
      cmp_idx_reg   <= '0;
      mode_reg      <= 1'b0;
      a_prev_reg    <= '0;
      vld0_reg      <= 1'b0;
      vld1_reg      <= 1'b0;
      exp_reg       <= 1'b0;
      exp_vld_reg   <= 1'b0;
      err_seen_reg  <= 1'b0;
      a_out         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else begin
      done <= 1'b0;

      // Expected b mirrors the datapath: f4 sees the vector one cycle older than f5.
      a_prev_reg  <= a_out;
      vld1_reg    <= vld0_reg;
      exp_reg     <= f4(a_prev_reg) & f5(a_out);
      exp_vld_reg <= vld0_reg & vld1_reg;

      if (exp_vld_reg) begin
        cmp_idx_reg <= cmp_idx_reg + CNT_W'(1);
      end
      if (mismatch) begin
        if (!(SAT_ERR && err_full)) begin
          err_count <= err_count + CNT_W'(1);
        end
        if (!err_seen_reg) begin
          first_err_idx <= cmp_idx_reg;
        end
        err_seen_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            err_count     <= '0;
            first_err_idx <= '0;
            pass          <= 1'b0;
            err_seen_reg  <= 1'b0;
            if (num_vec >= CNT_W'(2)) begin
              state_reg   <= RUN;
              a_out       <= seed_eff;
              vld0_reg    <= 1'b1;
              num_reg     <= num_vec;
              mode_reg    <= mode;
              idx_reg     <= '0;
              cmp_idx_reg <= '0;
              busy        <= 1'b1;
            end else begin
              state_reg <= DONE;
              done      <= 1'b1;
            end
          end
        end
        RUN: begin
          if (idx_reg == num_reg - CNT_W'(1)) begin
            a_out     <= '0;
            vld0_reg  <= 1'b0;
            state_reg <= DRAIN;
          end else begin
            a_out   <= a_next;
            idx_reg <= idx_reg + CNT_W'(1);
          end
        end
        DRAIN: begin
          // The last compare has just retired once no expected value is pending.
          if (!exp_vld_reg) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= !err_seen_reg;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_test_sequencer.sv
// Randomized self-checking bench for pipe_test_sequencer with a behavioural datapath
// driving dut_b and a vector-list reference model of the expected results.
module tb_pipe_test_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_in = 8'd0;
  logic       mode_in = 1'b0;
  logic [6:0] seed_in = 7'd0;
  logic [6:0] a_out;
  logic       dut_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [7:0] first_err_idx;

  int         n_tests = 0;
  int         n_fail = 0;
  int         bmode = 0;
  logic       flip_now = 1'b0;
  logic       dp4a = 1'b0;
  logic       dp4b = 1'b0;
  logic       dp5 = 1'b0;

  pipe_test_sequencer #(.CNT_W(8), .SAT_ERR(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_in), .mode(mode_in),
    .seed(seed_in), .a_out(a_out), .dut_b(dut_b), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  function automatic logic tb_f4(input logic [6:0] v);
    return ~(v[0] & v[1]) & ~v[2];
  endfunction

  function automatic logic tb_f5(input logic [6:0] v);
    return v[3] | v[4] | (v[5] & v[6]);
  endfunction

  // Behavioural datapath: two flops on the f4 path, one on the f5 path.
  always @(posedge clk) begin
    dp4a <= tb_f4(a_out);
    dp4b <= dp4a;
    dp5  <= tb_f5(a_out);
  end

  assign dut_b = (bmode == 1) ? 1'b1 : (bmode == 2) ? 1'b0 : ((dp4b & dp5) ^ flip_now);

  // k-th vector of a run, computed directly from the sequence rules.
  function automatic logic [6:0] vec_at(input logic m, input logic [6:0] s, input int k);
    logic [6:0] v;
    if (!m) return 7'((32'(s) + k) % 128);
    v = (s == 7'd0) ? 7'h01 : s;
    for (int i = 0; i < k; i++) v = {v[5:0], v[6] ^ v[5]};
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".a_out"}, 32'(a_out), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".pass"}, 32'(pass), 32'd0);
    check({tag, ".err_count"}, 32'(err_count), 32'd0);
    check({tag, ".first_err_idx"}, 32'(first_err_idx), 32'd0);
  endtask

  // bm: 0 = datapath model (optionally with injected flips), 1 = stuck-at-1, 2 = stuck-at-0.
  task automatic run_vec(input logic m, input logic [6:0] s, input int n, input int bm, input bit noise);
    logic [6:0] vv [0:255];
    logic       ee [0:255];
    logic       fl [0:255];
    logic       bval;
    int         exp_err;
    int         exp_first;
    exp_err   = 0;
    exp_first = -1;
    for (int k = 0; k < n; k++) vv[k] = vec_at(m, s, k);
    for (int k = 0; k <= n - 2; k++) begin
      ee[k] = tb_f4(vv[k]) & tb_f5(vv[k+1]);
      fl[k] = (bm == 0 && noise) ? ($urandom_range(0, 3) == 0) : 1'b0;
      bval  = (bm == 1) ? 1'b1 : (bm == 2) ? 1'b0 : (ee[k] ^ fl[k]);
      if (bval != ee[k]) begin
        if (exp_first < 0) exp_first = k;
        exp_err++;
      end
    end
    if (exp_err > 255) exp_err = 255;

    @(negedge clk);
    mode_in  = m;
    seed_in  = s;
    num_in   = 8'(n);
    start    = 1'b1;
    bmode    = bm;
    flip_now = 1'b0;
    @(posedge clk);
    for (int j = 0; j <= n + 3; j++) begin
      @(negedge clk);
      check("a_out", 32'(a_out), 32'((j < n) ? vv[j] : 7'd0));
      check("busy", 32'(busy), 32'(j < n + 2));
      check("done", 32'(done), 32'(j == n + 2));
      if (j >= 2 && j - 2 <= n - 2) flip_now = fl[j-2];
      else flip_now = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise && j <= n + 2) begin
        start   = 1'($urandom_range(0, 1));
        num_in  = 8'($urandom_range(0, 255));
        mode_in = 1'($urandom_range(0, 1));
        seed_in = 7'($urandom_range(0, 127));
      end else begin
        start = 1'b0;
      end
    end
    flip_now = 1'b0;
    check("pass", 32'(pass), 32'(exp_err == 0));
    check("err_count", 32'(err_count), 32'(exp_err));
    if (exp_err > 0) check("first_err_idx", 32'(first_err_idx), 32'(exp_first));
    $display("[TB] run mode=%0d seed=%02h n=%0d bmode=%0d exp_err=%0d exp_first=%0d err=%0d first=%0d pass=%0d",
             m, s, n, bm, exp_err, exp_first, err_count, first_err_idx, pass);
  endtask

  task automatic run_short(input int n);
    @(negedge clk);
    num_in = 8'(n);
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("short.done", 32'(done), 32'd1);
    check("short.busy", 32'(busy), 32'd0);
    check("short.pass", 32'(pass), 32'd0);
    check("short.err_count", 32'(err_count), 32'd0);
    check("short.a_out", 32'(a_out), 32'd0);
    @(negedge clk);
    check("short.done_end", 32'(done), 32'd0);
    check("short.busy_end", 32'(busy), 32'd0);
    $display("[TB] short n=%0d done=%0d busy=%0d pass=%0d", n, done, busy, pass);
  endtask

  task automatic run_reset_abort();
    int seen_done;
    seen_done = 0;
    @(negedge clk);
    mode_in = 1'b0;
    seed_in = 7'h05;
    num_in  = 8'd20;
    start   = 1'b1;
    bmode   = 0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort.a_out_pre", 32'(a_out), 32'h07);
    #2 rst = 1'b1;
    #1 check_idle_zero("abort");
    #3 rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("abort.no_done", 32'(seen_done), 32'd0);
    $display("[TB] reset abort after E_2 a_out=%02h busy=%0d done=%0d", a_out, busy, done);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_idle_zero("reset");
    repeat (3) @(posedge clk);
    #2 check_idle_zero("reset_hold");
    rst = 1'b0;

    run_vec(1'b0, 7'h00, 4, 0, 1'b0);
    run_vec(1'b0, 7'h00, 4, 1, 1'b0);
    run_vec(1'b0, 7'h08, 3, 2, 1'b0);
    run_vec(1'b0, 7'h7F, 2, 0, 1'b0);
    run_vec(1'b1, 7'h00, 8, 0, 1'b0);
    run_short(1);
    run_vec(1'b0, 7'h11, 5, 0, 1'b0);
    run_short(0);
    run_vec(1'b0, 7'h00, 4, 0, 1'b0);
    run_reset_abort();
    run_vec(1'b1, 7'h2A, 10, 0, 1'b0);
    for (int r = 0; r < 40; r++) begin
      run_vec(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
              $urandom_range(2, 40), $urandom_range(0, 2), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
